// File: rtl/demux_rr_dispatch.sv
// Round-robin dispatcher for a 1:4 demux: holds one accepted word and steers it to a ready
// sink, skipping busy sinks and re-steering a stalled word after a timeout.
`timescale 1ns/1ps

module demux_rr_dispatch #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic [1:0]        sel_o,
  output logic [3:0]        out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic [3:0]        out_ready_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  reroute_cnt_o
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    reroute_q, reroute_d;

  logic                xfer;
  logic                accept;
  logic [3:0]          others;
  logic [1:0]          sel_next;

  // First ready sink searching upward (mod 4) from base; base itself if none is ready.
  function automatic logic [1:0] pick(input logic [1:0] base, input logic [3:0] rdy);
    logic [1:0] res;
    logic [1:0] idx;
    res = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (rdy[idx]) res = idx;
    end
    return res;
  endfunction

  assign xfer       = (state_q == HOLD) && out_ready_i[sel_q];
  assign in_ready_o = rst_ni && en_i && ((state_q == IDLE) || out_ready_i[sel_q]);
  assign accept     = in_valid_i && in_ready_o;
  assign others     = out_ready_i & ~(4'b0001 << sel_q);
  assign sel_next   = sel_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    wait_d    = wait_q;
    reroute_d = reroute_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data_i;
          sel_d   = pick(ptr_q, out_ready_i);
          wait_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (xfer) begin
          ptr_d = sel_next;
          if (accept) begin
            data_d = in_data_i;
            sel_d  = pick(sel_next, out_ready_i);
            wait_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST) && (|others)) begin
          sel_d  = pick(sel_next, others);
          wait_d = '0;
          if (reroute_q != '1) reroute_d = reroute_q + 1'b1;
        end else if (wait_q != WAIT_SAT) begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      data_q    <= '0;
      wait_q    <= '0;
      reroute_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      wait_q    <= wait_d;
      reroute_q <= reroute_d;
    end
  end

  assign sel_o         = sel_q;
  assign out_data_o    = data_q;
  assign busy_o        = (state_q == HOLD);
  assign out_valid_o   = (state_q == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
  assign reroute_cnt_o = reroute_q;

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Bench for demux_rr_dispatch: directed scenarios plus random traffic, checked against a
// word-level dispatch model and a scoreboard queue of accepted words.
`timescale 1ns/1ps

module tb_demux_rr_dispatch;

  localparam int DATA_W = 8;
  localparam int TO     = 3;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready_o;
  logic [1:0]        sel_o;
  logic [3:0]        out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic [3:0]        out_ready;
  logic              busy_o;
  logic [CNT_W-1:0]  reroute_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] expQ[$];
  int                gotSinkQ[$];
  logic [DATA_W-1:0] gotDataQ[$];

  // Word-level model: is a word held, which sink it targets, how long it has waited.
  bit                mHolding;
  logic [DATA_W-1:0] mData;
  int                mSink, mAge, mPtr, mReroutes;

  demux_rr_dispatch #(.DATA_W(DATA_W), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready_o), .sel_o(sel_o), .out_valid_o(out_valid_o),
    .out_data_o(out_data_o), .out_ready_i(out_ready), .busy_o(busy_o),
    .reroute_cnt_o(reroute_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic int firstReady(input int start, input logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      if (mask[(start + k) % 4]) return (start + k) % 4;
    end
    return start;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic e, input logic v, input logic [DATA_W-1:0] d,
                               input logic [3:0] r);
    en = e;
    in_valid = v;
    in_data = d;
    out_ready = r;
  endtask

  // Present one word until it is taken, bounded so a stuck DUT still reaches the summary.
  task automatic sendWord(input logic [DATA_W-1:0] d);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data = d;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      done = in_ready_o;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: word 0x%0h got no in_ready, required in_ready=1", d);
    end
  endtask

  // Reference model, advanced on every active edge or asynchronous reset.
  initial begin
    mHolding = 0; mData = '0; mSink = 0; mAge = 0; mPtr = 0; mReroutes = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mHolding = 0; mData = '0; mSink = 0; mAge = 0; mPtr = 0; mReroutes = 0;
        expQ.delete();
      end else begin
        bit acc;
        logic [3:0] oth;
        acc = in_valid && en && (!mHolding || out_ready[mSink]);
        oth = out_ready & ~(4'b0001 << mSink);
        if (mHolding && out_ready[mSink]) begin
          mPtr = (mSink + 1) % 4;
          if (acc) begin
            mData = in_data; mSink = firstReady(mPtr, out_ready); mAge = 0;
            expQ.push_back(in_data);
          end else begin
            mHolding = 0;
          end
        end else if (mHolding) begin
          if (TO != 0 && mAge == TO - 1 && oth != 4'b0000) begin
            mSink = firstReady((mSink + 1) % 4, oth);
            mAge = 0;
            if (mReroutes < (1 << CNT_W) - 1) mReroutes++;
          end else if (mAge < TO) begin
            mAge++;
          end
        end else if (acc) begin
          mHolding = 1; mData = in_data; mSink = firstReady(mPtr, out_ready); mAge = 0;
          expQ.push_back(in_data);
        end
      end
    end
  end

  // Monitor: compares visible outputs each cycle and scores every transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic [3:0] expValid;
        expValid = mHolding ? (4'b0001 << mSink) : 4'b0000;
        checkOutput("out_valid", out_valid_o, expValid);
        checkOutput("busy", busy_o, mHolding);
        checkOutput("in_ready", in_ready_o, en && (!mHolding || out_ready[mSink]));
        checkOutput("reroute_cnt", reroute_cnt_o, mReroutes);
        if (mHolding) begin
          checkOutput("sel", sel_o, mSink);
          checkOutput("out_data", out_data_o, mData);
        end
        for (int i = 0; i < 4; i++) begin
          if (out_valid_o[i] && out_ready[i]) begin
            gotSinkQ.push_back(i);
            gotDataQ.push_back(out_data_o);
            if (expQ.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL extra_transfer: sink %0d data 0x%0h, required no transfer",
                       i, out_data_o);
            end else begin
              checkOutput("xfer_data", out_data_o, expQ.pop_front());
              checkOutput("xfer_sink", i, mSink);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int expSinks[8];
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, '0, 4'b1111);
    step(2);
    checkOutput("rst_out_valid", out_valid_o, 4'b0000);
    checkOutput("rst_sel", sel_o, 2'd0);
    checkOutput("rst_out_data", out_data_o, '0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_in_ready", in_ready_o, 1'b0);
    checkOutput("rst_reroute", reroute_cnt_o, '0);
    #2 rst_n = 1'b1;
    step(1);

    $display("[TB] scenario 1: back-to-back round robin");
    gotSinkQ.delete(); gotDataQ.delete();
    for (int w = 0; w < 8; w++) begin
      sendWord(DATA_W'(8'h10 + w));
      if (w == 0) checkOutput("first_valid_latency", out_valid_o, 4'b0001);
    end
    step(3);
    expSinks = '{0, 1, 2, 3, 0, 1, 2, 3};
    checkOutput("s1_count", gotSinkQ.size(), 8);
    for (int w = 0; w < 8 && w < gotSinkQ.size(); w++) begin
      checkOutput("s1_sink", gotSinkQ[w], expSinks[w]);
      checkOutput("s1_data", gotDataQ[w], 8'h10 + w);
    end

    $display("[TB] scenario 2: skip sinks not ready");
    gotSinkQ.delete(); gotDataQ.delete();
    out_ready = 4'b1010;
    sendWord(8'hA1);
    sendWord(8'hA2);
    step(3);
    checkOutput("s2_count", gotSinkQ.size(), 2);
    if (gotSinkQ.size() == 2) begin
      checkOutput("s2_sink_a1", gotSinkQ[0], 1);
      checkOutput("s2_sink_a2", gotSinkQ[1], 3);
    end

    $display("[TB] scenario 3: timeout re-steer");
    gotSinkQ.delete(); gotDataQ.delete();
    out_ready = 4'b0000;
    sendWord(8'h55);
    step(2);
    out_ready = 4'b0100;
    step(1);
    checkOutput("s3_sel", sel_o, 2'd2);
    step(2);
    checkOutput("s3_reroute", reroute_cnt_o, 1);
    checkOutput("s3_count", gotSinkQ.size(), 1);
    if (gotSinkQ.size() == 1) begin
      checkOutput("s3_sink", gotSinkQ[0], 2);
      checkOutput("s3_data", gotDataQ[0], 8'h55);
    end

    $display("[TB] scenario 4: long stall with no ready sink");
    out_ready = 4'b0000;
    sendWord(8'h33);
    step(50);
    checkOutput("s4_valid", out_valid_o, 4'b1000);
    checkOutput("s4_in_ready", in_ready_o, 1'b0);
    checkOutput("s4_reroute", reroute_cnt_o, 1);
    out_ready = 4'b1111;
    step(2);

    $display("[TB] scenario 5: enable dropped mid-hold");
    gotSinkQ.delete(); gotDataQ.delete();
    out_ready = 4'b0000;
    sendWord(8'h77);
    applyStimulus(1'b0, 1'b1, 8'h99, 4'b1111);
    step(3);
    checkOutput("s5_busy", busy_o, 1'b0);
    checkOutput("s5_in_ready", in_ready_o, 1'b0);
    checkOutput("s5_count_held", gotSinkQ.size(), 1);
    en = 1'b1;
    sendWord(8'h99);
    step(2);
    checkOutput("s5_count", gotSinkQ.size(), 2);
    if (gotSinkQ.size() == 2) begin
      checkOutput("s5_data0", gotDataQ[0], 8'h77);
      checkOutput("s5_sink1", gotSinkQ[1], 1);
    end

    $display("[TB] scenario 6: reset mid-hold");
    out_ready = 4'b0000;
    sendWord(8'h44);
    step(1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6_valid", out_valid_o, 4'b0000);
    checkOutput("s6_sel", sel_o, 2'd0);
    checkOutput("s6_busy", busy_o, 1'b0);
    checkOutput("s6_reroute", reroute_cnt_o, '0);
    step(1);
    #2 rst_n = 1'b1;
    gotSinkQ.delete(); gotDataQ.delete();
    out_ready = 4'b1111;
    step(1);
    sendWord(8'h66);
    step(2);
    checkOutput("s6_count", gotSinkQ.size(), 1);
    if (gotSinkQ.size() == 1) begin
      checkOutput("s6_sink", gotSinkQ[0], 0);
      checkOutput("s6_data", gotDataQ[0], 8'h66);
    end

    $display("[TB] scenario 7: random traffic");
    for (int c = 0; c < 600; c++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      applyStimulus(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                    DATA_W'($urandom_range(0, 255)), r);
      step(1);
    end
    applyStimulus(1'b1, 1'b0, '0, 4'b1111);
    step(4);
    checkOutput("drain_pending", expQ.size(), 0);
    checkOutput("drain_busy", busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
